// File: rtl/ether_tx_pkg.sv
// Shared types and constants for the Ethernet transmit path.
// CRC constants are reused by the receive-side checksum.
package ether_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    DATA,
    FCS,
    IFG
  } tx_state_t;

  localparam logic [31:0] CRC32_POLY = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE = 8'hD5;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ether_tx_crc32_byte.sv
// One-byte reflected CRC-32 update, purely combinational.
// Shared with the receive-side checksum.
module crc32_byte
  import ether_tx_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  din,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      c = (c >> 1) ^ ({32{c[0] ^ din[i]}} & CRC32_POLY);
    end
    crc_out = c;
  end

endmodule

// File: rtl/ether_tx.sv
// Byte-stream to RMII dibit transmitter: preamble, SFD,
// payload, CRC-32 FCS and inter-frame gap.
module ether_tx
  import ether_tx_pkg::*;
#(
  parameter int PREAMBLE_BYTES = 7,
  parameter int IFG_BYTES = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] axiid,
  input  logic       axiiv,
  input  logic       axiilast,
  output logic       axiir,
  output logic [1:0] axiod,
  output logic       axiov,
  output logic       busy,
  output logic       underrun
);

  localparam int MAXB = max3(PREAMBLE_BYTES, IFG_BYTES, 4);
  localparam int BW = (MAXB > 2) ? $clog2(MAXB) : 1;
  localparam logic [BW-1:0] PRE_LAST = BW'(PREAMBLE_BYTES - 1);
  localparam logic [BW-1:0] IFG_LAST = BW'(IFG_BYTES - 1);
  localparam logic [BW-1:0] FCS_LAST = BW'(3);
  localparam logic [BW-1:0] ONE = BW'(1);

  tx_state_t state, state_n;
  logic [1:0]    dcnt, dcnt_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [7:0]    dbyte, dbyte_n;
  logic          dlast, dlast_n;
  logic [31:0]   crc, crc_n, crc_upd, fcs;
  logic [7:0]    obyte;
  logic [1:0]    od_n;
  logic          ov_n, ir_n, busy_n, und_n;
  logic          accept;

  assign accept = axiiv & axiir;

  crc32_byte u_crc (
    .crc_in  (crc),
    .din     (axiid),
    .crc_out (crc_upd)
  );

  always_comb begin
    state_n = state;
    dcnt_n  = dcnt + 2'd1;
    bcnt_n  = bcnt;
    dbyte_n = dbyte;
    dlast_n = dlast;
    crc_n   = crc;
    und_n   = 1'b0;
    if (accept) begin
      dbyte_n = axiid;
      dlast_n = axiilast;
      crc_n   = crc_upd;
    end
    case (state)
      IDLE: begin
        dcnt_n = 2'd0;
        if (axiiv) begin
          state_n = PREAMBLE;
          bcnt_n  = '0;
          crc_n   = CRC32_INIT;
        end
      end
      PREAMBLE: begin
        if (dcnt == 2'd3) begin
          if (bcnt == PRE_LAST) begin
            state_n = SFD;
            bcnt_n  = '0;
          end else begin
            bcnt_n = bcnt + ONE;
          end
        end
      end
      SFD, DATA: begin
        if (dcnt == 2'd3) begin
          if (state == DATA && dlast) begin
            state_n = FCS;
            bcnt_n  = '0;
          end else if (accept) begin
            state_n = DATA;
          end else begin
            // IFG starts at dibit 1: the IDLE cycle closes the gap
            state_n = IFG;
            und_n   = 1'b1;
            bcnt_n  = '0;
            dcnt_n  = 2'd1;
          end
        end
      end
      FCS: begin
        if (dcnt == 2'd3) begin
          if (bcnt == FCS_LAST) begin
            state_n = IFG;
            bcnt_n  = '0;
            dcnt_n  = 2'd1;
          end else begin
            bcnt_n = bcnt + ONE;
          end
        end
      end
      IFG: begin
        if (dcnt == 2'd3) begin
          if (bcnt == IFG_LAST) begin
            state_n = IDLE;
            bcnt_n  = '0;
            dcnt_n  = 2'd0;
          end else begin
            bcnt_n = bcnt + ONE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        dcnt_n  = 2'd0;
        bcnt_n  = '0;
      end
    endcase
  end

  always_comb begin
    fcs   = ~crc_n;
    obyte = 8'h00;
    unique case (1'b1)
      (state_n == PREAMBLE): obyte = PREAMBLE_BYTE;
      (state_n == SFD):      obyte = SFD_BYTE;
      (state_n == DATA):     obyte = dbyte_n;
      (state_n == FCS):
        obyte = fcs[{bcnt_n[1:0], 3'b000} +: 8];
      default:               obyte = 8'h00;
    endcase
    ov_n = (state_n == PREAMBLE) || (state_n == SFD)
        || (state_n == DATA) || (state_n == FCS);
    od_n = ov_n ? obyte[{dcnt_n, 1'b0} +: 2] : 2'b00;
    ir_n = (dcnt_n == 2'd3)
        && ((state_n == SFD)
        || ((state_n == DATA) && !dlast_n));
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      dcnt     <= 2'd0;
      bcnt     <= '0;
      dbyte    <= 8'h00;
      dlast    <= 1'b0;
      crc      <= CRC32_INIT;
      axiod    <= 2'b00;
      axiov    <= 1'b0;
      axiir    <= 1'b0;
      busy     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state    <= state_n;
      dcnt     <= dcnt_n;
      bcnt     <= bcnt_n;
      dbyte    <= dbyte_n;
      dlast    <= dlast_n;
      crc      <= crc_n;
      axiod    <= od_n;
      axiov    <= ov_n;
      axiir    <= ir_n;
      busy     <= busy_n;
      underrun <= und_n;
    end
  end

endmodule

// File: tb/tb_ether_tx.sv
// Directed bench for ether_tx: frame contents, FCS,
// gaps, underrun and mid-frame reset.
module tb_ether_tx;

  typedef logic [7:0] byteq_t[$];
  typedef bit bitq_t[$];

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] axiid;
  logic       axiiv;
  logic       axiilast;
  logic       axiir;
  logic [1:0] axiod;
  logic       axiov;
  logic       busy;
  logic       underrun;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ether_tx dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .axiid    (axiid),
    .axiiv    (axiiv),
    .axiilast (axiilast),
    .axiir    (axiir),
    .axiod    (axiod),
    .axiov    (axiov),
    .busy     (busy),
    .underrun (underrun)
  );

  // line monitor
  logic [1:0] cur_q[$];
  logic [7:0] fr_q[$];
  int cyc = 0, rdy_cnt = 0, rdy_cyc = 0;
  int und_cnt = 0, und_cyc = 0, od_bad = 0;
  int fr_ov = 0, nframes = 0, nstart = 0;
  int gap_run = 0, gap_last = 0;
  logic ov_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (axiir === 1'b1) begin
      rdy_cnt++;
      rdy_cyc = cyc;
    end
    if (underrun === 1'b1) begin
      und_cnt++;
      und_cyc = cyc;
    end
    if (axiov !== 1'b1 && axiod !== 2'b00) od_bad++;
    if (axiov === 1'b1) begin
      if (!ov_prev) begin
        gap_last = gap_run;
        cur_q.delete();
        nstart++;
      end
      cur_q.push_back(axiod);
    end else begin
      if (ov_prev) begin
        fr_q.delete();
        for (int k = 0; k + 3 < cur_q.size(); k += 4)
          fr_q.push_back({cur_q[k+3], cur_q[k+2],
                          cur_q[k+1], cur_q[k]});
        fr_ov = cur_q.size();
        nframes++;
        gap_run = 0;
      end
      gap_run++;
    end
    ov_prev = (axiov === 1'b1);
  end

  function automatic logic [31:0] crc_bits(
    input logic [31:0] c,
    input logic [7:0] b
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
      else r = r >> 1;
    end
    return r;
  endfunction

  // receive-side checksum over the reassembled frame
  function automatic void rx_check(
    input byteq_t q,
    output logic done,
    output logic kill
  );
    logic [31:0] c;
    logic pre_ok;
    c = 32'hFFFFFFFF;
    pre_ok = 1'b1;
    done = (q.size() >= 13);
    kill = 1'b1;
    if (done) begin
      for (int i = 0; i < 7; i++)
        if (q[i] !== 8'h55) pre_ok = 1'b0;
      if (q[7] !== 8'hD5) pre_ok = 1'b0;
      for (int i = 8; i < q.size(); i++)
        c = crc_bits(c, q[i]);
      kill = !pre_ok || (c !== 32'hDEBB20E3);
    end
  endfunction

  function automatic byteq_t exp_frame(
    input byteq_t pay,
    input logic [31:0] fcs
  );
    byteq_t q;
    for (int i = 0; i < 7; i++) q.push_back(8'h55);
    q.push_back(8'hD5);
    foreach (pay[i]) q.push_back(pay[i]);
    for (int i = 0; i < 4; i++) q.push_back(fcs[8*i +: 8]);
    return q;
  endfunction

  function automatic bitq_t mk_last(input int n);
    bitq_t l;
    for (int i = 0; i < n; i++) l.push_back(i == n - 1);
    return l;
  endfunction

  task automatic drive(
    input byteq_t d,
    input bitq_t l,
    input int stop
  );
    int i = 0;
    int guard = 0;
    logic r;
    axiiv = 1'b1;
    axiid = d[0];
    axiilast = l[0];
    while (i < d.size() && i != stop && guard < 3000) begin
      @(negedge clk);
      r = axiir;
      @(posedge clk);
      #1;
      guard++;
      if (r === 1'b1) begin
        i++;
        if (i < d.size() && i != stop) begin
          axiid = d[i];
          axiilast = l[i];
        end else begin
          axiiv = 1'b0;
          axiilast = 1'b0;
        end
      end
    end
    if (guard >= 3000) begin
      total++;
      bad++;
      axiiv = 1'b0;
      $display("FAIL drive_timeout: sent %0d of %0d", i, d.size());
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: busy=%b want 0", busy);
    end
  endtask

  byteq_t p123 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                   8'h36, 8'h37, 8'h38, 8'h39};
  byteq_t p00 = '{8'h00};

  task automatic test_reset();
    rst_n = 1'b0;
    axiiv = 1'b0;
    axiid = 8'h00;
    axiilast = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({axiov, axiod, axiir, busy, underrun} !== 6'b0) begin
      bad++;
      $display("FAIL reset_out: got %b want 000000",
               {axiov, axiod, axiir, busy, underrun});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({axiov, busy, axiir} !== 3'b000) begin
      bad++;
      $display("FAIL idle_after_reset: got %b want 000",
               {axiov, busy, axiir});
    end
  endtask

  task automatic check_frame(
    input string nm,
    input byteq_t e,
    input int ov_len
  );
    logic done, kill;
    logic [7:0] g;
    total++;
    if (fr_q.size() != e.size()) begin
      bad++;
      $display("FAIL %s_len: got %0d want %0d", nm,
               fr_q.size(), e.size());
    end
    for (int i = 0; i < e.size(); i++) begin
      g = (i < fr_q.size()) ? fr_q[i] : 8'hxx;
      total++;
      if (g !== e[i]) begin
        bad++;
        $display("FAIL %s_byte%0d: got %h want %h", nm, i, g, e[i]);
      end
    end
    total++;
    if (fr_ov != ov_len) begin
      bad++;
      $display("FAIL %s_ov: got %0d want %0d", nm, fr_ov, ov_len);
    end
    rx_check(fr_q, done, kill);
    total++;
    if (done !== 1'b1 || kill !== 1'b0) begin
      bad++;
      $display("FAIL %s_rx: got done=%b kill=%b want 1 0",
               nm, done, kill);
    end
  endtask

  task automatic test_basic();
    rdy_cnt = 0;
    drive(p123, mk_last(9), -1);
    wait_idle();
    check_frame("basic", exp_frame(p123, 32'hCBF43926), 84);
    total++;
    if (rdy_cnt != 9) begin
      bad++;
      $display("FAIL basic_ready: got %0d want 9", rdy_cnt);
    end
  endtask

  task automatic test_single();
    rdy_cnt = 0;
    drive(p00, mk_last(1), -1);
    wait_idle();
    check_frame("single", exp_frame(p00, 32'hD202EF8D), 52);
    total++;
    if (rdy_cnt != 1) begin
      bad++;
      $display("FAIL single_ready: got %0d want 1", rdy_cnt);
    end
  endtask

  task automatic test_back_to_back();
    byteq_t d;
    bitq_t l;
    int nf0, n;
    d = p123;
    d.push_back(8'h00);
    l = mk_last(9);
    l.push_back(1'b1);
    nf0 = nframes;
    drive(d, l, -1);
    n = 0;
    while (nframes < nf0 + 2 && n < 500) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (nframes != nf0 + 2) begin
      bad++;
      $display("FAIL b2b_frames: got %0d want %0d",
               nframes - nf0, 2);
    end
    total++;
    if (gap_last != 48) begin
      bad++;
      $display("FAIL b2b_gap: got %0d want 48", gap_last);
    end
    check_frame("b2b2", exp_frame(p00, 32'hD202EF8D), 52);
    wait_idle();
  endtask

  task automatic test_underrun();
    byteq_t d = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    int und0, n;
    und0 = und_cnt;
    drive(d, mk_last(5), 2);
    n = 0;
    while (und_cnt == und0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (und_cnt != und0 + 1) begin
      bad++;
      $display("FAIL und_seen: got %0d want %0d",
               und_cnt - und0, 1);
    end
    total++;
    if (und_cyc - rdy_cyc != 1) begin
      bad++;
      $display("FAIL und_delay: got %0d want 1", und_cyc - rdy_cyc);
    end
    @(negedge clk);
    total++;
    if ({busy, axiov, underrun} !== 3'b100) begin
      bad++;
      $display("FAIL und_ifg: got %b want 100",
               {busy, axiov, underrun});
    end
    total++;
    if (fr_ov != 40 || fr_q.size() != 10) begin
      bad++;
      $display("FAIL und_frame: got ov=%0d n=%0d want 40 10",
               fr_ov, fr_q.size());
    end
    total++;
    if (fr_q.size() == 10 && fr_q[9] !== 8'hA2) begin
      bad++;
      $display("FAIL und_last: got %h want a2", fr_q[9]);
    end
    drive(p123, mk_last(9), -1);
    total++;
    if (gap_last != 48) begin
      bad++;
      $display("FAIL und_gap: got %0d want 48", gap_last);
    end
    wait_idle();
    check_frame("after_und", exp_frame(p123, 32'hCBF43926), 84);
    total++;
    if (und_cnt != und0 + 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL und_end: got und=%0d busy=%b want 1 0",
               und_cnt - und0, busy);
    end
  endtask

  task automatic test_reset_fcs();
    int s0, n;
    s0 = nstart;
    drive(p123, mk_last(9), -1);
    n = 0;
    while (!(nstart > s0 && cur_q.size() >= 72) && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({axiov, axiod, axiir, busy, underrun} !== 6'b0) begin
      bad++;
      $display("FAIL rst_fcs_out: got %b want 000000",
               {axiov, axiod, axiir, busy, underrun});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rdy_cnt = 0;
    drive(p123, mk_last(9), -1);
    wait_idle();
    check_frame("post_rst", exp_frame(p123, 32'hCBF43926), 84);
  endtask

  task automatic test_idle_od();
    total++;
    if (od_bad != 0) begin
      bad++;
      $display("FAIL od_idle: got %0d want 0", od_bad);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_back_to_back();
    test_underrun();
    test_reset_fcs();
    test_idle_od();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
